// File: rtl/booth_seq_mult_if.sv
// Start/done handshake bundle for booth_seq_mult.
// The slave accepts start only while busy=0. Operands are sampled on that edge.
// done pulses for one cycle when product updates. start while busy=1 is dropped.
interface booth_seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     mcand;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, mplier, mcand,
    input  busy, done, product
  );

  modport slave (
    input  start, mplier, mcand,
    output busy, done, product
  );
endinterface

// File: rtl/booth_seq_mult.sv
// Iterative signed Booth multiplier with one shared add/shift datapath.
// Default build is radix-2. Defining BOOTH_RADIX4_EN selects radix-4 with a 2M path.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  booth_seq_mult_if.slave  bus,
  output logic             dbg_state_o
);

`ifdef BOOTH_RADIX4_EN
  localparam int SH = 2;
`else
  localparam int SH = 1;
`endif
  localparam int N    = WIDTH / SH;
  localparam int AW   = WIDTH + SH;
  localparam int SW   = AW + SH;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 4) begin : g_width_min
    $error("booth_seq_mult: WIDTH must be at least 4");
  end
  if ((WIDTH % SH) != 0) begin : g_width_even
    $error("booth_seq_mult: WIDTH must be even for radix-4");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       a_q, a_d;
  logic [WIDTH:0]      q_q, q_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic                done_q, done_d;

  logic [SW-1:0]       a_ext, m_ext, sum;
`ifdef BOOTH_RADIX4_EN
  logic [SW-1:0]       m2_ext;
`endif
  logic [AW-1:0]       a_step;
  logic [WIDTH:0]      q_step;

  // The sum is sign-extended by SH bits so the arithmetic shift takes its true sign.
  always_comb begin
    a_ext = {{SH{a_q[AW-1]}}, a_q};
    m_ext = {{(SW-WIDTH){m_q[WIDTH-1]}}, m_q};
    sum   = a_ext;
`ifdef BOOTH_RADIX4_EN
    m2_ext = {m_ext[SW-2:0], 1'b0};
    case (q_q[2:0])
      3'b001, 3'b010: sum = a_ext + m_ext;
      3'b011:         sum = a_ext + m2_ext;
      3'b100:         sum = a_ext - m2_ext;
      3'b101, 3'b110: sum = a_ext - m_ext;
      default:        sum = a_ext;
    endcase
`else
    case (q_q[1:0])
      2'b01:   sum = a_ext + m_ext;
      2'b10:   sum = a_ext - m_ext;
      default: sum = a_ext;
    endcase
`endif
    a_step = sum[SW-1:SH];
    q_step = {sum[SH-1:0], q_q[WIDTH:SH]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = '0;
          q_d     = {bus.mcand, 1'b0};
          m_d     = bus.mplier;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          product_d = {a_step[WIDTH-1:0], q_step[WIDTH:1]};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (radix-2 by default, radix-4 with BOOTH_RADIX4_EN).
module tb_booth_seq_mult;
  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int N = W / 2;
`else
  localparam int N = W;
`endif
  localparam int TMO = 4 * N + 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  booth_seq_mult_if #(.WIDTH(W)) bus ();

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // behavioural model: N cycles of latency, product = signed a*b
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] prod_q[$];
  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pending = '0;
  int             m_left = 0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_left = 0;
      prod_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_prod = m_pending;
        end
      end else if (bus.start) begin
        m_busy    = 1'b1;
        m_left    = N;
        m_pending = ref_mul(bus.mplier, bus.mcand);
        prod_q.push_back(m_pending);
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("product", 32'(bus.product), 32'(m_prod));
    if (bus.done) begin
      if (prod_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: done with no accepted operation (cycle %0d)", cyc);
      end else begin
        check("scoreboard", 32'(bus.product), 32'(prod_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mplier = a;
    bus.mcand  = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mplier = W'($urandom);
    bus.mcand  = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles", TMO);
    end
  endtask

  task automatic count_dones(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] lit, input string nm);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({nm, "_latency"}, 32'(lat), 32'(N));
    check(nm, 32'(bus.product), 32'(lit));
  endtask

  logic [W-1:0]   ba[3];
  logic [W-1:0]   bb[3];
  logic [2*W-1:0] blit[3];
  int             done_cyc[3];

  initial begin
    int lat;
    int cnt;
    bus.start  = 1'b0;
    bus.mplier = '0;
    bus.mcand  = '0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
    rst = 1'b0;

    directed(8'd5, 8'd6, 16'h001E, "p5x6");

    // back-to-back with start held high
    ba[0] = 8'hFB; bb[0] = 8'd6;  blit[0] = 16'hFFE2;
    ba[1] = 8'hFB; bb[1] = 8'hFA; blit[1] = 16'h001E;
    ba[2] = 8'd5;  bb[2] = 8'hFA; blit[2] = 16'hFFE2;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mplier = ba[0];
    bus.mcand  = bb[0];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        bus.mplier = ba[k+1];
        bus.mcand  = bb[k+1];
      end else begin
        bus.start = 1'b0;
      end
      wait_done(lat);
      done_cyc[k] = cyc;
      check("b2b_latency", 32'(lat), 32'(N));
      check("b2b_product", 32'(bus.product), 32'(blit[k]));
      if (k > 0) check("b2b_spacing", 32'(done_cyc[k] - done_cyc[k-1]), 32'(N + 1));
      @(negedge clk);
    end

    directed(8'h80, 8'h80, 16'h4000, "pmin_x_min");
    directed(8'h80, 8'h7F, 16'hC080, "pmin_x_max");
    directed(8'h00, 8'hFF, 16'h0000, "p0_x_m1");

    // start while busy is ignored
    start_op(8'd7, 8'd9);
    repeat (2) @(negedge clk);
    bus.start  = 1'b1;
    bus.mplier = 8'd3;
    bus.mcand  = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    check("ignore_product", 32'(bus.product), 32'h003F);
    count_dones(2 * N + 4, cnt);
    check("ignore_no_second_done", 32'(cnt), 32'd0);

    // reset mid-run
    start_op(8'd11, 8'd13);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(2 * N + 4, cnt);
    check("midrst_no_done", 32'(cnt), 32'd0);
    directed(8'd2, 8'd3, 16'h0006, "p2x3");

    // randomized pairs
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(W'($urandom), W'($urandom));
      wait_done(lat);
      check("rand_latency", 32'(lat), 32'(N));
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(prod_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
